// File: rtl/wsa_pkg.sv
// wsa_pkg: shared widths and tap helpers for the window_sum_arbiter slice
//   PIX_W  pixel (tap) width
//   TAPS   taps per window
//   WIN_W  packed window width
//   PSUM_W width of a 4-tap partial sum (4*255 = 1020)
//   SUM_W  width of the full 9-tap sum (9*255 = 2295)
package wsa_pkg;

    localparam int PIX_W  = 8;
    localparam int TAPS   = 9;
    localparam int WIN_W  = PIX_W * TAPS;
    localparam int PSUM_W = 10;
    localparam int SUM_W  = 12;

    // Sum of four consecutive taps starting at tap index base.
    function automatic logic [PSUM_W-1:0] psum4(input logic [WIN_W-1:0] win, input int base);
        logic [PSUM_W-1:0] s;
        s = '0;
        for (int k = 0; k < 4; k++)
            s = s + PSUM_W'(win[PIX_W*(base+k) +: PIX_W]);
        return s;
    endfunction

endpackage

// File: rtl/window_adder9_pipe.sv
// window_adder9_pipe: two-stage 9-tap window adder carrying owner id and valid
//   clk, rst   clock, asynchronous active-high reset
//   in_valid   window presented this cycle (captured unconditionally)
//   in_id      owner id of the window
//   in_win     packed 9-tap window
//   s1_valid   stage register holds a window (feeds the credit check)
//   out_valid  final sum available this cycle (same as s1_valid)
//   out_id     owner id of out_sum
//   out_sum    12-bit sum of all 9 taps
module window_adder9_pipe
    import wsa_pkg::*;
#(
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDW-1:0]   in_id,
    input  logic [WIN_W-1:0] in_win,
    output logic             s1_valid,
    output logic             out_valid,
    output logic [IDW-1:0]   out_id,
    output logic [SUM_W-1:0] out_sum
);

    logic [PSUM_W-1:0] psum_lo;
    logic [PSUM_W-1:0] psum_hi;
    logic [SUM_W-1:0]  tap8;
    logic [IDW-1:0]    s1_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            psum_lo  <= '0;
            psum_hi  <= '0;
            tap8     <= '0;
            s1_id    <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                psum_lo <= psum4(in_win, 0);
                psum_hi <= psum4(in_win, 4);
                tap8    <= SUM_W'(in_win[PIX_W*8 +: PIX_W]);
                s1_id   <= in_id;
            end
        end
    end

    // Second stage is purely combinational; the FIFO write is its register.
    assign out_valid = s1_valid;
    assign out_id    = s1_id;
    assign out_sum   = SUM_W'(psum_lo) + SUM_W'(psum_hi) + tap8;

endmodule

// File: rtl/window_sum_arbiter.sv
// window_sum_arbiter: shares one 9-tap window adder among N_REQ requesters
//   clk, rst   clock, asynchronous active-high reset
//   req_valid  per-requester window valid
//   req_ready  per-requester grant (one-hot or zero, combinational)
//   req_win    requester i window at [72*i+71:72*i]
//   res_valid  result available (FIFO non-empty, first-word-fall-through)
//   res_ready  downstream accepts result
//   res_sum    9-tap sum, res_id owner of that sum
//   busy       adder stage or FIFO holds data
// Build option: define WSA_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no pointer register); default is round-robin.
module window_sum_arbiter
    import wsa_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int DEPTH = 4,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIN_W-1:0] req_win,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SUM_W-1:0]       res_sum,
    output logic [IDW-1:0]         res_id,
    output logic                   busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDW-1:0]   gid;
    logic             found;
    logic             credit_ok;
    logic             accept;
    logic [OW-1:0]    occ;
    logic             s1_valid;
    logic             a_valid;
    logic [IDW-1:0]   a_id;
    logic [SUM_W-1:0] a_sum;
    logic [CW-1:0]    fifo_count;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [SUM_W-1:0] mem_sum [DEPTH];
    logic [IDW-1:0]   mem_id  [DEPTH];

`ifndef WSA_FIXED_PRIO_EN
    logic [IDW-1:0] ptr;
`endif

    // Credit counts the window in the adder stage as already occupying a
    // FIFO slot; a pop in this same cycle is not credited back.
    assign occ       = {1'b0, fifo_count} + OW'(s1_valid);
    assign credit_ok = occ < OW'(DEPTH);

    always_comb begin : arb
        int idx;
        found = 1'b0;
        gid   = '0;
        for (int o = 0; o < N_REQ; o++) begin
`ifdef WSA_FIXED_PRIO_EN
            idx = o;
`else
            idx = int'(ptr) + o;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
`endif
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gid   = IDW'(idx);
            end
        end
    end

    assign req_ready = (found && credit_ok) ? (N_REQ'(1) << gid) : '0;
    assign accept    = |(req_valid & req_ready);

`ifndef WSA_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (accept)
            ptr <= (gid == IDW'(N_REQ - 1)) ? '0 : gid + 1'b1;
    end
`endif

    window_adder9_pipe #(.IDW(IDW)) u_add (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_id     (gid),
        .in_win    (req_win[WIN_W*gid +: WIN_W]),
        .s1_valid  (s1_valid),
        .out_valid (a_valid),
        .out_id    (a_id),
        .out_sum   (a_sum)
    );

    assign push = a_valid;
    assign pop  = res_valid & res_ready;

    // Storage needs no reset: the read side is gated by res_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_sum[wr_ptr] <= a_sum;
            mem_id[wr_ptr]  <= a_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    assign res_valid = fifo_count != '0;
    assign res_sum   = res_valid ? mem_sum[rd_ptr] : '0;
    assign res_id    = res_valid ? mem_id[rd_ptr] : '0;
    assign busy      = s1_valid | res_valid;

endmodule

// File: tb/tb_window_sum_arbiter.sv
// tb_window_sum_arbiter: randomized scoreboard bench for window_sum_arbiter
module tb_window_sum_arbiter;

    localparam int N   = 3;
    localparam int D   = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*72-1:0] req_win;
    logic           res_valid;
    logic           res_ready;
    logic [11:0]    res_sum;
    logic [IDW-1:0] res_id;
    logic           busy;

    window_sum_arbiter #(.N_REQ(N), .DEPTH(D), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_win   (req_win),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_pop = 0;
    int mptr  = 0;
    int dut_acc = 0;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference arbitration: grant only while fewer than D windows are
    // outstanding (accepted but not yet delivered), then round-robin or
    // lowest-index priority among valid requesters.
    function automatic logic [N-1:0] model_ready(input logic [N-1:0] v);
        int idx;
        if (n_acc - n_pop >= D)
            return '0;
        for (int o = 0; o < N; o++) begin
`ifdef WSA_FIXED_PRIO_EN
            idx = o;
`else
            idx = (mptr + o) % N;
`endif
            if (v[idx])
                return N'(1) << idx;
        end
        return '0;
    endfunction

    task automatic step(input logic [N-1:0] v, input logic rr, input int mode);
        logic [N-1:0] exp_r;
        logic [7:0]   t;
        int           w;
        int           s;
        @(negedge clk);
        req_valid = v;
        res_ready = rr;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 9; k++) begin
                t = (mode == 2) ? 8'hFF : (mode == 1) ? 8'(i + 1) : 8'($urandom_range(0, 255));
                req_win[i*72 + k*8 +: 8] = t;
            end
        #1;
        exp_r = model_ready(v);
        chk("req_ready", int'(req_ready), int'(exp_r));
        if (|(req_valid & req_ready))
            dut_acc++;
        if (|(v & exp_r)) begin
            w = 0;
            for (int i = 0; i < N; i++)
                if (exp_r[i]) w = i;
            s = 0;
            for (int k = 0; k < 9; k++)
                s += int'(req_win[w*72 + k*8 +: 8]);
            exp_q.push_back(w * 4096 + s);
            n_acc++;
            mptr = (w + 1) % N;
        end
    endtask

    // Monitor: pops the scoreboard on every delivered result and checks
    // output stability under backpressure.
    logic           hold_pend = 1'b0;
    logic [11:0]    hold_sum;
    logic [IDW-1:0] hold_id;
    int             e;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            chk("outstanding_le_depth", int'(n_acc - n_pop <= D), 1);
            if (hold_pend && res_valid) begin
                chk("hold_sum", int'(res_sum), int'(hold_sum));
                chk("hold_id", int'(res_id), int'(hold_id));
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_sum", int'(res_sum), e % 4096);
                    chk("res_id", int'(res_id), e / 4096);
                end
                n_pop++;
            end
            hold_pend = res_valid && !res_ready;
            hold_sum  = res_sum;
            hold_id   = res_id;
        end
    end

    int base;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        req_win   = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_sum", int'(res_sum), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single transfer, latency 2
        step(3'b001, 1'b1, 2);
        step(3'b000, 1'b1, 0);
        chk("lat1_valid_t1", int'(res_valid), 0);
        step(3'b000, 1'b1, 0);
        chk("lat1_valid_t2", int'(res_valid), 1);
        chk("lat1_sum", int'(res_sum), 2295);
        chk("lat1_id", int'(res_id), 0);

        // Pointer now at 1: requesters 2 and 0 alternate
        repeat (4) step(3'b101, 1'b1, 0);

        // All valid, one accept per cycle
        base = dut_acc;
        repeat (6) step(3'b111, 1'b1, 1);
        chk("all_valid_accepts", dut_acc - base, 6);
        repeat (4) step(3'b000, 1'b1, 0);

        // Backpressure: exactly D accepts, then stall
        base = dut_acc;
        repeat (8) step(3'b111, 1'b0, 0);
        chk("bp_accepts", dut_acc - base, D);
        chk("bp_busy", int'(busy), 1);
        chk("bp_ready_zero", int'(req_ready), 0);
        base = dut_acc;
        repeat (10) step(3'b111, 1'b1, 0);
        chk("bp_resume", int'(dut_acc - base > 0), 1);
        repeat (8) step(3'b000, 1'b1, 0);
        chk("drain_empty", exp_q.size(), 0);

        // Reset with 2 buffered and 1 in flight
        repeat (3) step(3'b001, 1'b0, 0);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_res_valid", int'(res_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        exp_q.delete();
        n_acc = 0;
        n_pop = 0;
        mptr  = 0;
        @(negedge clk);
        rst = 1'b0;
        step(3'b001, 1'b1, 2);
        step(3'b000, 1'b1, 0);
        chk("lat2_valid_t1", int'(res_valid), 0);
        step(3'b000, 1'b1, 0);
        chk("lat2_valid_t2", int'(res_valid), 1);
        chk("lat2_sum", int'(res_sum), 2295);

        // Random traffic
        repeat (400) step(N'($urandom), $urandom_range(0, 9) < 7, 0);
        repeat (12) step(3'b000, 1'b1, 0);
        chk("final_empty", exp_q.size(), 0);
        chk("final_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
